cell_tester: RTL and testbench
==============================

CELL_TESTER -- requirements
Module: cell_tester

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 4, cycles a vector is held before sampling (1..255).
REQ-002 SHALL have parameter PASSES, default 16, full truth-table sweeps per run (1..65535).
REQ-003 SHALL have parameter ERR_W, default 8, error-counter width.
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port start  input  1  run request, sampled in IDLE only.
REQ-007 SHALL have port abort  input  1  terminate run, return to IDLE.
REQ-008 SHALL have port dut_y  input  1  output of the 2-input NAND cell under test.
REQ-009 SHALL have port dut_a  output  1  registered drive to cell input A.
REQ-010 SHALL have port dut_b  output  1  registered drive to cell input B.
REQ-011 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-012 SHALL have port done  output  1  one-cycle pulse on run completion.
REQ-013 SHALL have port pass  output  1  result of last completed run; held until next accepted start.
REQ-014 SHALL have port err_count  output  ERR_W  mismatches in current/last run.

Function
REQ-015 SHALL implement states IDLE, DRIVE, SETTLE, SAMPLE, DONE.
REQ-016 SHALL, in IDLE with start=1 and abort=0, go to DRIVE next cycle and clear err_count, pass, vector index and pass counter.
REQ-017 SHALL apply vectors {dut_a,dut_b} in order 00, 01, 10, 11 per sweep, updating dut_a/dut_b on the DRIVE cycle.
REQ-018 SHALL stay in SETTLE exactly SETTLE_CYCLES cycles, then go to SAMPLE.
REQ-019 SHALL, in SAMPLE, compare dut_y against expected ~(dut_a & dut_b); mismatch increments err_count.
REQ-020 SHALL saturate err_count at 2^ERR_W-1; no wrap-around.
REQ-021 SHALL go from SAMPLE to DRIVE with next vector; after vector 11, pass counter increments and vector index wraps to 00.
REQ-022 SHALL go to DONE after SAMPLE of vector 11 in sweep PASSES; total run length = PASSES*4*(SETTLE_CYCLES+2) cycles from first DRIVE to DONE.
REQ-023 SHALL, in DONE, pulse done=1, set pass=(err_count==0 including final sample), drive dut_a=dut_b=0, return to IDLE next cycle.
REQ-024 SHALL ignore start while busy.
REQ-025 SHALL, on abort=1 in any non-IDLE state, go to IDLE next cycle, discard any same-cycle sample, hold err_count, leave pass unchanged, drive dut_a=dut_b=0, no done pulse.
REQ-026 SHALL give abort priority over start when both are high in IDLE (remain IDLE).

Reset
REQ-027 SHALL, on rst=1, force IDLE and dut_a=0, dut_b=0, busy=0, done=0, pass=0, err_count=0 next edge, including mid-run.
REQ-028 SHALL give rst priority over start and abort.

Configuration
REQ-029 SHALL, with macro CELL_TESTER_FIRST_FAIL_EN defined, add outputs first_fail_valid (1) and first_fail_vec (2, {a,b}) capturing the first mismatching vector of a run; both cleared by reset and accepted start, held after done/abort.
REQ-030 SHALL, without CELL_TESTER_FIRST_FAIL_EN, omit both ports; all other behaviour identical.

Verification (SETTLE_CYCLES=4, PASSES=2, ERR_W=8 unless stated)
REQ-031 SHALL test: correct NAND model, start pulse -> done exactly 48 cycles after first DRIVE, err_count=0, pass=1.
REQ-032 SHALL test: dut_y stuck-at-1 -> err_count=2, pass=0, first_fail_vec=11, first_fail_valid=1 (macro on).
REQ-033 SHALL test: ERR_W=2, dut_y stuck-at-0 -> 6 mismatches saturate err_count=3, pass=0.
REQ-034 SHALL test: abort at cycle 20 of run -> IDLE next cycle, no done, dut_a=dut_b=0, err_count held.
REQ-035 SHALL test: rst at cycle 30 of run -> all outputs 0 next cycle; start while busy and start+abort in IDLE ignored.

Source files
------------

// File: rtl/cell_tester_if.sv
// Control/status and cell-drive bundle for cell_tester.
// CELL_TESTER_FIRST_FAIL_EN adds the first-failing-vector capture signals.
interface cell_tester_if #(
    parameter int unsigned ERR_W = 8
);
    logic             start;
    logic             abort;
    logic             dut_y;
    logic             dut_a;
    logic             dut_b;
    logic             busy;
    logic             done;
    logic             pass;
    logic [ERR_W-1:0] err_count;
`ifdef CELL_TESTER_FIRST_FAIL_EN
    logic             first_fail_valid;
    logic [1:0]       first_fail_vec;

    modport master (
        output start, abort, dut_y,
        input  dut_a, dut_b, busy, done, pass, err_count, first_fail_valid, first_fail_vec
    );
    modport slave (
        input  start, abort, dut_y,
        output dut_a, dut_b, busy, done, pass, err_count, first_fail_valid, first_fail_vec
    );
`else
    modport master (
        output start, abort, dut_y,
        input  dut_a, dut_b, busy, done, pass, err_count
    );
    modport slave (
        input  start, abort, dut_y,
        output dut_a, dut_b, busy, done, pass, err_count
    );
`endif
endinterface

// File: rtl/cell_tester.sv
// Sweeps a 2-input NAND cell through its truth table PASSES times and counts mismatches.
// Optional macro CELL_TESTER_FIRST_FAIL_EN enables first-failing-vector capture.
module cell_tester #(
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned PASSES        = 16,
    parameter int unsigned ERR_W         = 8
) (
    input  logic         clk,
    input  logic         rst,
    cell_tester_if.slave bus
);
    localparam int unsigned SET_W  = 8;
    localparam int unsigned PASS_W = 16;
    localparam logic [ERR_W-1:0] ERR_MAX = '1;

    typedef enum logic [2:0] {IDLE, DRIVE, SETTLE, SAMPLE, DONE} state_t;

    state_t              state, state_n;
    logic [1:0]          vec, vec_n;
    logic [PASS_W-1:0]   sweep, sweep_n;
    logic [SET_W-1:0]    scnt, scnt_n;
    logic                a_q, a_n, b_q, b_n;
    logic                busy_q, busy_n, done_q, done_n, pass_q, pass_n;
    logic [ERR_W-1:0]    err_q, err_n;
    logic                mismatch_c;
`ifdef CELL_TESTER_FIRST_FAIL_EN
    logic                ffv_q, ffv_n;
    logic [1:0]          ffvec_q, ffvec_n;
`endif

    assign mismatch_c = (bus.dut_y != ~(a_q & b_q));

    // Next-state and next-output logic; every output register is loaded from here.
    always_comb begin
        state_n = state;
        vec_n   = vec;
        sweep_n = sweep;
        scnt_n  = scnt;
        a_n     = a_q;
        b_n     = b_q;
        err_n   = err_q;
        pass_n  = pass_q;
`ifdef CELL_TESTER_FIRST_FAIL_EN
        ffv_n   = ffv_q;
        ffvec_n = ffvec_q;
`endif
        case (state)
            IDLE: begin
                if (bus.start && !bus.abort) begin
                    state_n = DRIVE;
                    vec_n   = 2'd0;
                    sweep_n = '0;
                    err_n   = '0;
                    pass_n  = 1'b0;
`ifdef CELL_TESTER_FIRST_FAIL_EN
                    ffv_n   = 1'b0;
                    ffvec_n = 2'd0;
`endif
                end
            end
            DRIVE: begin
                state_n = SETTLE;
                scnt_n  = '0;
            end
            SETTLE: begin
                if (scnt == SET_W'(SETTLE_CYCLES - 1)) state_n = SAMPLE;
                else                                   scnt_n  = scnt + SET_W'(1);
            end
            SAMPLE: begin
                if (mismatch_c) begin
                    if (err_q != ERR_MAX) err_n = err_q + ERR_W'(1);
`ifdef CELL_TESTER_FIRST_FAIL_EN
                    if (!ffv_q) begin
                        ffv_n   = 1'b1;
                        ffvec_n = {a_q, b_q};
                    end
`endif
                end
                if (vec == 2'd3) begin
                    if (sweep == PASS_W'(PASSES - 1)) begin
                        state_n = DONE;
                    end else begin
                        state_n = DRIVE;
                        sweep_n = sweep + PASS_W'(1);
                        vec_n   = 2'd0;
                    end
                end else begin
                    state_n = DRIVE;
                    vec_n   = vec + 2'd1;
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase

        // Abort drops any sample taken this cycle and leaves pass alone.
        if (state != IDLE && bus.abort) begin
            state_n = IDLE;
            err_n   = err_q;
`ifdef CELL_TESTER_FIRST_FAIL_EN
            ffv_n   = ffv_q;
            ffvec_n = ffvec_q;
`endif
        end

        if (state_n == DRIVE)                         {a_n, b_n} = vec_n;
        else if (state_n == IDLE || state_n == DONE)  {a_n, b_n} = 2'b00;
        if (state_n == DONE) pass_n = (err_n == '0);
        busy_n = (state_n != IDLE);
        done_n = (state_n == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            vec     <= 2'd0;
            sweep   <= '0;
            scnt    <= '0;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= '0;
`ifdef CELL_TESTER_FIRST_FAIL_EN
            ffv_q   <= 1'b0;
            ffvec_q <= 2'd0;
`endif
        end else begin
            state   <= state_n;
            vec     <= vec_n;
            sweep   <= sweep_n;
            scnt    <= scnt_n;
            a_q     <= a_n;
            b_q     <= b_n;
            busy_q  <= busy_n;
            done_q  <= done_n;
            pass_q  <= pass_n;
            err_q   <= err_n;
`ifdef CELL_TESTER_FIRST_FAIL_EN
            ffv_q   <= ffv_n;
            ffvec_q <= ffvec_n;
`endif
        end
    end

    assign bus.dut_a     = a_q;
    assign bus.dut_b     = b_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.pass      = pass_q;
    assign bus.err_count = err_q;
`ifdef CELL_TESTER_FIRST_FAIL_EN
    assign bus.first_fail_valid = ffv_q;
    assign bus.first_fail_vec   = ffvec_q;
`endif
endmodule

// File: tb/tb_cell_tester.sv
// Bench for cell_tester: two instances (ERR_W=8 and ERR_W=2) driven in lockstep by a
// truth-table cell model, checked every cycle against a sample-count reference model.
module tb_cell_tester;
    localparam int S   = 4;
    localparam int P   = 2;
    localparam int RUN = P * 4 * (S + 2);

    logic       clk = 1'b0;
    logic       rst, start, abort;
    logic [3:0] tbl;
    int         vectors = 0;
    int         miscompares = 0;

    always #5 clk = ~clk;

    cell_tester_if #(.ERR_W(8)) ifa ();
    cell_tester_if #(.ERR_W(2)) ifb ();

    assign ifa.start = start;
    assign ifa.abort = abort;
    assign ifb.start = start;
    assign ifb.abort = abort;
    assign ifa.dut_y = tbl[{ifa.dut_a, ifa.dut_b}];
    assign ifb.dut_y = tbl[{ifb.dut_a, ifb.dut_b}];

    cell_tester #(.SETTLE_CYCLES(S), .PASSES(P), .ERR_W(8)) u_a (.clk(clk), .rst(rst), .bus(ifa.slave));
    cell_tester #(.SETTLE_CYCLES(S), .PASSES(P), .ERR_W(2)) u_b (.clk(clk), .rst(rst), .bus(ifb.slave));

    wire [31:0] obs_a = {19'd0, ifa.busy, ifa.done, ifa.pass, ifa.dut_a, ifa.dut_b, ifa.err_count};
    wire [31:0] obs_b = {25'd0, ifb.busy, ifb.done, ifb.pass, ifb.dut_a, ifb.dut_b, ifb.err_count};

    // Reference: the cell is good on vector v iff its output equals NAND of (a,b).
    function automatic bit cell_ok(input logic [3:0] t, input int v);
        bit a = (v >= 2);
        bit b = (v % 2 == 1);
        return t[v] == !(a && b);
    endfunction

    // Sample i (vector i%4) happens (S+2)*i+S+1 cycles after the first DRIVE.
    function automatic int model_err(input logic [3:0] t, input int stop, input int maxv);
        int n = 0;
        for (int i = 0; i < P * 4; i++)
            if ((S + 2) * i + S + 1 < stop && !cell_ok(t, i % 4)) n++;
        return (n > maxv) ? maxv : n;
    endfunction

    function automatic logic [31:0] model_ff(input logic [3:0] t, input int stop);
        for (int i = 0; i < P * 4; i++)
            if ((S + 2) * i + S + 1 < stop && !cell_ok(t, i % 4)) return 32'(4 + (i % 4));
        return 32'd0;
    endfunction

    function automatic logic [31:0] exp_word(input logic busy, input logic done, input logic pass,
                                             input logic a, input logic b, input int err, input int w);
        logic [31:0] r;
        r = 32'({busy, done, pass, a, b}) << w;
        return r | 32'(err);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag, input logic [3:0] t, input logic busy, input logic done,
                               input logic pass, input logic a, input logic b, input int stop);
        check({tag, "/w8"}, obs_a, exp_word(busy, done, pass, a, b, model_err(t, stop, 255), 8));
        check({tag, "/w2"}, obs_b, exp_word(busy, done, pass, a, b, model_err(t, stop, 3), 2));
`ifdef CELL_TESTER_FIRST_FAIL_EN
        check({tag, "/ff8"}, 32'({ifa.first_fail_valid, ifa.first_fail_vec}), model_ff(t, stop));
        check({tag, "/ff2"}, 32'({ifb.first_fail_valid, ifb.first_fail_vec}), model_ff(t, stop));
`endif
    endtask

    // One run; abort_at/rst_at/start_at are cycles after first DRIVE (-1 = never).
    task automatic run(input string nm, input logic [3:0] t, input int abort_at, input int rst_at,
                       input int start_at);
        logic [1:0] vv;
        bit         good;
        tbl = t;
        good = (model_err(t, RUN, 1000) == 0);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        for (int c = 0; c <= RUN; c++) begin
            start = 1'b0;
            if (c < RUN) begin
                vv = 2'((c / (S + 2)) % 4);
                check_state({nm, "/run"}, t, 1'b1, 1'b0, 1'b0, vv[1], vv[0], c);
            end else begin
                check_state({nm, "/done"}, t, 1'b1, 1'b1, good, 1'b0, 1'b0, RUN);
            end
            if (c == abort_at) begin
                abort = 1'b1;
                @(negedge clk) abort = 1'b0;
                check_state({nm, "/abort"}, t, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, abort_at);
                return;
            end
            if (c == rst_at) begin
                rst = 1'b1;
                @(negedge clk) rst = 1'b0;
                check_state({nm, "/rst"}, t, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
                return;
            end
            if (c == start_at) start = 1'b1;
            @(negedge clk);
        end
        check_state({nm, "/idle"}, t, 1'b0, 1'b0, good, 1'b0, 1'b0, RUN);
    endtask

    initial begin
        logic [3:0] rt;
        int         ab;
        rst = 1'b1; start = 1'b0; abort = 1'b0; tbl = 4'b0111;
        repeat (2) @(negedge clk);
        check_state("reset", tbl, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        rst = 1'b0;

        run("nand",   4'b0111, -1, -1, 10);
        run("stuck1", 4'b1111, -1, -1, -1);
        run("stuck0", 4'b0000, -1, -1, -1);

        @(negedge clk) begin start = 1'b1; abort = 1'b1; end
        @(negedge clk) begin start = 1'b0; abort = 1'b0; end
        check_state("start_abort_idle", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, RUN);

        run("abort20", 4'b0000, 20, -1, -1);
        run("rst30",   4'b1010, -1, 30, -1);
        run("nand2",   4'b0111, -1, -1, -1);

        for (int k = 0; k < 8; k++) begin
            rt = 4'($urandom);
            ab = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, RUN - 1)) : -1;
            run("rand", rt, ab, -1, int'($urandom_range(0, RUN - 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
